sent_tx_frame_ctrl: RTL
=======================

# sent_tx_frame_ctrl

Frame sequencer for the SENT (SAE J2716) transmitter; sits directly upstream of the pulse generator. Accepts a status nibble plus data nibbles over a valid/ready handshake, computes the SENT CRC‑4, and drives the generator's one‑hot `sync` / `pulse` / `pause` requests with `data_nibble`. Advances one symbol per `pulse_done`. Includes a one‑frame holding buffer so frames can be sent back‑to‑back.

## Interface
- `NUM_NIBBLES`, 6: data nibbles per frame, 1..6.
- `PAUSE_EN`, 1: 1 = append a pause pulse after CRC; 0 = no pause.
- `CRC_RECOMMENDED`, 1: 1 = J2716 recommended CRC with an extra zero nibble; 0 = legacy CRC.

Ports:
- `ticks  in  1`: transmit tick clock; all logic on posedge.
- `reset  in  1`: asynchronous, active‑low; clears all state.
- `frame_valid  in  1`: upstream frame offered.
- `frame_ready  out  1`: buffer empty; frame accepted when valid && ready.
- `status_in  in  4`: status/communication nibble.
- `data_in  in  24`: data nibbles. Nibble 0 = `[23:20]`, sent first; only the top `NUM_NIBBLES` nibbles are used.
- `pulse_done  in  1`: from the generator; current symbol complete.
- `sync  out  1`: sync pulse request.
- `pulse  out  1`: nibble pulse request.
- `pause  out  1`: pause pulse request.
- `data_nibble  out  4`: nibble value for `pulse`.
- `busy  out  1`: a frame is in progress (state ≠ IDLE).
- `frame_done  out  1`: one‑tick strobe after the last symbol completes.

## Operation
- States: IDLE, SYNC, STATUS, DATA, CRC, PAUSE.
- **Holding buffer:** one entry with status and data. `frame_ready = !buf_full`.
- **IDLE:**
  - If `buf_full`: load the buffer into the working registers, clear `buf_full`, seed CRC = 4'h5, go to SYNC.
  - If empty: stay in IDLE.
- **SYNC:** `sync = 1`. On `pulse_done`, go to STATUS.
- **STATUS:** `pulse = 1`, `data_nibble = status`. On `pulse_done`, go to DATA with `idx = 0`.
  - The status nibble is excluded from the CRC.
- **DATA:** `pulse = 1`, `data_nibble = nibble[idx]`. On `pulse_done`:
  - Update `crc = T[crc] ^ nibble[idx]`.
  - If `idx == NUM_NIBBLES-1`, go to CRC; else increment `idx`.
- **CRC:** `pulse = 1`, `data_nibble = crc_final`.
  - Recommended mode: `crc_final = T[crc]`, i.e. the extra zero nibble.
  - Legacy mode: `crc_final = crc`.
  - On `pulse_done`: go to PAUSE if `PAUSE_EN`, else finish.
- **PAUSE:** `pause = 1`. On `pulse_done`, finish.
- **Finish:**
  - Pulse `frame_done` for one tick.
  - If `buf_full`: load the next frame and go directly to SYNC (no IDLE tick). Otherwise go to IDLE.
- **CRC table:** T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}, indexed by the current CRC; 4‑bit arithmetic, no carry.
- **Request outputs:**
  - Registered and mutually exclusive (one‑hot or all zero).
  - All zero in IDLE.
  - `data_nibble` is held stable while `pulse` is high and is 0 otherwise.
- `pulse_done` is ignored in IDLE.

## Timing
- **Reset values:** `sync = pulse = pause = 0`, `data_nibble = 0`, `busy = 0`, `frame_done = 0`, `frame_ready = 1`, buffer empty, state IDLE.
- **Accept to sync:** with the block in IDLE and the buffer empty, a frame accepted at edge N sets `buf_full` at N. The controller leaves IDLE at N+1, so `sync` is high after edge N+1 (2‑tick latency).
- **Symbol change:** on the edge where `pulse_done` is sampled high, the next request and nibble are registered in that same edge. No idle tick between symbols.
- **Simultaneous accept and load:** if a frame is accepted on the same edge that the buffer is loaded, the new frame goes into the buffer and `buf_full` stays 1.
- **Back‑to‑back frames:** the `frame_done` edge and the next `sync` assertion occur on the same edge.
- **Reset mid‑frame:** all requests drop immediately (asynchronous). The in‑flight frame and the buffered frame are discarded.
- **Minimum frame:** `NUM_NIBBLES = 1` gives the symbol sequence SYNC, STATUS, DATA, CRC[, PAUSE].

## Structure
- **Shared package `sent_pkg`:**
  - CRC‑4 table and seed (4'h5).
  - State enum for this block.
  - Symbol tick constants: sync 56, nibble 12+n, frame length 250, low time 5.
- **Sub‑module `sent_crc4`:** combinational, `crc_next = T[crc_in] ^ nib_in`. Instantiated for the DATA update; also used for the recommended final step with `nib_in = 0`.

## Test plan
- **Reset:** `reset` low with `frame_valid` high → all outputs at reset values, `frame_ready = 1`, no request asserted.
- **Default parameters, all‑zero frame:** status 4'h0, data 24'h000000 → sequence sync, pulse 0 ×7, then CRC nibble 4'h5, then pause; `frame_done` once.
- **Legacy CRC:** status 4'h3, data 24'h123456, `CRC_RECOMMENDED = 0` → nibbles 3,1,2,3,4,5,6, then CRC 4'hD; with `CRC_RECOMMENDED = 1`, CRC = 4'h2.
- **Back‑to‑back:** two frames offered, the second during DATA → `frame_ready` low after the second accept; `sync` of frame 2 on the same edge as frame 1's `frame_done`.
- **Short frame, no pause:** `NUM_NIBBLES = 3`, `PAUSE_EN = 0`, data 24'hABCxxx → pulses A, B, C, then CRC; no `pause` assertion; returns to IDLE.
- **Reset mid‑DATA:** assert `reset` during DATA → all requests 0, `frame_ready = 1`. The next accepted frame starts with `sync` and a fresh CRC seed.

Source files
------------

// File: rtl/sent_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sent_pkg
// Description : Shared definitions for the SENT (SAE J2716) transmitter:
//               CRC-4 table and seed, frame sequencer state encoding and
//               symbol tick constants.
// Revision    : 1.0 - initial release
// ============================================================================
package sent_pkg;

    // CRC-4 seed loaded at the start of every frame.
    localparam logic [3:0] CRC4_SEED = 4'h5;

    // Symbol lengths in transmit ticks.
    localparam int unsigned SYNC_TICKS        = 56;   // sync pulse
    localparam int unsigned NIBBLE_BASE_TICKS = 12;   // nibble n lasts 12+n
    localparam int unsigned FRAME_TICKS       = 250;  // fixed frame length
    localparam int unsigned LOW_TICKS         = 5;    // low portion of a pulse

    // Frame sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_STATUS = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC    = 3'd4,
        ST_PAUSE  = 3'd5
    } tx_state_e;

    // CRC-4 lookup: T[crc], 4-bit result, no carry.
    function automatic logic [3:0] crc4_table(input logic [3:0] idx);
        logic [3:0] t;
        case (idx)
            4'd0:    t = 4'd0;
            4'd1:    t = 4'd13;
            4'd2:    t = 4'd7;
            4'd3:    t = 4'd10;
            4'd4:    t = 4'd14;
            4'd5:    t = 4'd3;
            4'd6:    t = 4'd9;
            4'd7:    t = 4'd4;
            4'd8:    t = 4'd1;
            4'd9:    t = 4'd12;
            4'd10:   t = 4'd6;
            4'd11:   t = 4'd11;
            4'd12:   t = 4'd15;
            4'd13:   t = 4'd2;
            4'd14:   t = 4'd8;
            default: t = 4'd5;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sent_crc4.sv
`default_nettype none
// ============================================================================
// Module      : sent_crc4
// Description : One SENT CRC-4 step, combinational: crc_next = T[crc_in]^nib_in.
// Ports       : crc_in   - current CRC
//               nib_in   - nibble being folded in (0 for the final step)
//               crc_next - updated CRC
// Revision    : 1.0 - initial release
// ============================================================================
module sent_crc4
    import sent_pkg::*;
(
    input  logic [3:0] crc_in,
    input  logic [3:0] nib_in,
    output logic [3:0] crc_next
);

    assign crc_next = crc4_table(crc_in) ^ nib_in;

endmodule
`default_nettype wire

// File: rtl/sent_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sent_tx_frame_ctrl
// Description : SENT transmit frame sequencer. Accepts status + data nibbles
//               into a one-frame holding buffer, computes the CRC-4 and issues
//               one-hot sync/pulse/pause requests to the pulse generator,
//               advancing one symbol per pulse_done.
// Ports       : ticks        - transmit tick clock (posedge)
//               reset        - asynchronous, active-low
//               frame_valid  - upstream frame offered
//               frame_ready  - holding buffer empty
//               status_in    - status/communication nibble
//               data_in      - data nibbles, nibble 0 in [23:20]
//               pulse_done   - generator finished current symbol
//               sync/pulse/pause - registered symbol requests
//               data_nibble  - nibble value for pulse (0 otherwise)
//               busy         - frame in progress
//               frame_done   - one-tick strobe after the last symbol
// Revision    : 1.0 - initial release
// ============================================================================
module sent_tx_frame_ctrl
    import sent_pkg::*;
#(
    parameter int unsigned NUM_NIBBLES     = 6,
    parameter bit          PAUSE_EN        = 1'b1,
    parameter bit          CRC_RECOMMENDED = 1'b1
) (
    input  logic        ticks,
    input  logic        reset,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [3:0]  status_in,
    input  logic [23:0] data_in,
    input  logic        pulse_done,
    output logic        sync,
    output logic        pulse,
    output logic        pause,
    output logic [3:0]  data_nibble,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_NIBBLES - 1);

    tx_state_e   state_q, state_d;
    logic        buf_full_q, buf_full_d;
    logic [3:0]  buf_status_q, buf_status_d;
    logic [23:0] buf_data_q, buf_data_d;
    logic [3:0]  status_q, status_d;
    logic [23:0] data_q, data_d;       // working data, current nibble in [23:20]
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  crc_q, crc_d;
    logic        sync_q, sync_d;
    logic        pulse_q, pulse_d;
    logic        pause_q, pause_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        frame_done_q, frame_done_d;

    logic        accept;
    logic        load;
    logic        finish;
    logic [3:0]  crc_upd;
    logic [3:0]  crc_final;

    assign accept = frame_valid && !buf_full_q;

    sent_crc4 u_crc_data (
        .crc_in   (crc_q),
        .nib_in   (data_q[23:20]),
        .crc_next (crc_upd)
    );

    // The CRC nibble is computed from the next-cycle CRC so it can be
    // registered together with the transition into CRC.
    generate
        if (CRC_RECOMMENDED) begin : g_crc_recommended
            sent_crc4 u_crc_final (
                .crc_in   (crc_d),
                .nib_in   (4'h0),
                .crc_next (crc_final)
            );
        end else begin : g_crc_legacy
            assign crc_final = crc_d;
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge ticks or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            buf_full_q   <= 1'b0;
            buf_status_q <= 4'h0;
            buf_data_q   <= 24'h0;
            status_q     <= 4'h0;
            data_q       <= 24'h0;
            idx_q        <= 3'd0;
            crc_q        <= 4'h0;
            sync_q       <= 1'b0;
            pulse_q      <= 1'b0;
            pause_q      <= 1'b0;
            nibble_q     <= 4'h0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_full_q   <= buf_full_d;
            buf_status_q <= buf_status_d;
            buf_data_q   <= buf_data_d;
            status_q     <= status_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            crc_q        <= crc_d;
            sync_q       <= sync_d;
            pulse_q      <= pulse_d;
            pause_q      <= pause_d;
            nibble_q     <= nibble_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        data_d       = data_q;
        idx_d        = idx_q;
        crc_d        = crc_q;
        buf_status_d = buf_status_q;
        buf_data_d   = buf_data_q;
        load         = 1'b0;
        finish       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (buf_full_q) begin
                    load = 1'b1;
                end
            end
            ST_SYNC: begin
                if (pulse_done) begin
                    state_d = ST_STATUS;
                end
            end
            ST_STATUS: begin
                if (pulse_done) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (pulse_done) begin
                    crc_d  = crc_upd;
                    data_d = {data_q[19:0], 4'h0};
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CRC;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_CRC: begin
                if (pulse_done) begin
                    if (PAUSE_EN) begin
                        state_d = ST_PAUSE;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (pulse_done) begin
                    finish = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A buffered frame chains straight into SYNC without an IDLE tick.
        if (finish) begin
            if (buf_full_q) begin
                load = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (load) begin
            state_d  = ST_SYNC;
            status_d = buf_status_q;
            data_d   = buf_data_q;
            idx_d    = 3'd0;
            crc_d    = CRC4_SEED;
        end

        // A new accept refills the buffer even on the edge it is drained.
        buf_full_d = buf_full_q;
        if (accept) begin
            buf_full_d   = 1'b1;
            buf_status_d = status_in;
            buf_data_d   = data_in;
        end else if (load) begin
            buf_full_d = 1'b0;
        end
    end

    // Registered requests decoded from the next state.
    always_comb begin
        sync_d       = (state_d == ST_SYNC);
        pulse_d      = (state_d == ST_STATUS) || (state_d == ST_DATA) ||
                       (state_d == ST_CRC);
        pause_d      = (state_d == ST_PAUSE);
        frame_done_d = finish;
        case (state_d)
            ST_STATUS: nibble_d = status_d;
            ST_DATA:   nibble_d = data_d[23:20];
            ST_CRC:    nibble_d = crc_final;
            default:   nibble_d = 4'h0;
        endcase
    end

    assign frame_ready = !buf_full_q;
    assign sync        = sync_q;
    assign pulse       = pulse_q;
    assign pause       = pause_q;
    assign data_nibble = nibble_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;

endmodule
`default_nettype wire
